// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
//
// Frame: 16-bit little-endian word count (len), then 4*len payload bytes.
// Payload byte i is written to byte address i, one write per accepted byte,
// one cycle after acceptance. The core is held in reset while a load runs.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailing checksum byte follows the payload. It must equal
//   the XOR of the two header bytes and every payload byte, or the load ends
//   in ERR (payload bytes are still written before the check).
//
// Handshake: a byte on in_data is consumed on a rising clk edge exactly when
// in_valid && in_ready are both high at that edge. in_ready depends only on
// the current state, never on in_valid, so the producer may hold in_valid
// high indefinitely; dropping in_valid simply stalls the frame with no
// timeout. The memory port has no back-pressure: every mem_we pulse is a
// completed byte write.
//
// o_dbg_state exposes the FSM state encoding for checkers.

module imem_loader #(
    parameter int addr_ins_width = 32,
    parameter int memory_width   = 8,
    parameter int memory_height  = 2048
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [addr_ins_width-1:0] mem_addr,
    output logic [memory_width-1:0]   mem_wdata,
    output logic                      core_hold,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                o_dbg_state
);

    // Largest accepted word count; anything above would overrun the memory.
    localparam logic [31:0] LP_MAX_WORDS = 32'(memory_height / 4);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_LOAD   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK    = 3'd4,
`endif
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // Where the FSM goes once the payload (possibly empty) has been taken.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LP_AFTER_PAYLOAD = ST_CHK;
`else
    localparam state_t LP_AFTER_PAYLOAD = ST_DONE;
`endif

    state_t        r_state;
    state_t        w_state_next;

    logic [17:0]   r_cnt;        // payload byte index (16-bit words * 4)
    logic [15:0]   r_len;        // word count from the header
    logic          r_mem_we;
    logic [addr_ins_width-1:0] r_mem_addr;
    logic [memory_width-1:0]   r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    r_xor;        // running XOR over header and payload
`endif

    logic          w_ready;
    logic          w_accept;
    logic          w_start_ok;
    logic [15:0]   w_len_full;
    logic          w_len_over;
    logic          w_len_zero;
    logic [17:0]   w_cnt_inc;
    logic          w_last;

    // Full header value as it becomes known on the LEN_HI byte.
    assign w_len_full = {in_data, r_len[7:0]};
    assign w_len_over = ({16'd0, w_len_full} > LP_MAX_WORDS);
    assign w_len_zero = (w_len_full == 16'd0);

    // Last payload byte is index 4*len-1, i.e. the incremented index hits 4*len.
    assign w_cnt_inc  = r_cnt + 18'd1;
    assign w_last     = (w_cnt_inc == {r_len, 2'b00});

    assign w_accept   = in_valid && w_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) ||
                                  (r_state == ST_DONE) ||
                                  (r_state == ST_ERR));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        core_hold    = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                w_ready   = 1'b1;
                core_hold = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                w_ready   = 1'b1;
                core_hold = 1'b1;
                if (in_valid) begin
                    if (w_len_over) begin
                        w_state_next = ST_ERR;
                    end else if (w_len_zero) begin
                        w_state_next = LP_AFTER_PAYLOAD;
                    end else begin
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_ready   = 1'b1;
                core_hold = 1'b1;
                if (in_valid && w_last) begin
                    w_state_next = LP_AFTER_PAYLOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                w_ready   = 1'b1;
                core_hold = 1'b1;
                if (in_valid) begin
                    w_state_next = (in_data == r_xor) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_next = ST_LEN_LO;
                end
            end
            ST_ERR: begin
                err = 1'b1;
                if (start) begin
                    w_state_next = ST_LEN_LO;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Header capture, byte counter and the registered memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 18'd0;
            r_len       <= 16'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok) begin
                r_cnt <= 18'd0;
                r_len <= 16'd0;
            end
            if (w_accept) begin
                case (r_state)
                    ST_LEN_LO: r_len[7:0]  <= in_data;
                    ST_LEN_HI: r_len[15:8] <= in_data;
                    ST_LOAD: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= addr_ins_width'(r_cnt);
                        r_mem_wdata <= memory_width'(in_data);
                        r_cnt       <= w_cnt_inc;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over header and payload bytes; cleared on each new load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xor <= 8'd0;
        end else if (w_start_ok) begin
            r_xor <= 8'd0;
        end else if (w_accept && ((r_state == ST_LEN_LO) ||
                                  (r_state == ST_LEN_HI) ||
                                  (r_state == ST_LOAD))) begin
            r_xor <= r_xor ^ in_data;
        end
    end
`endif

    assign in_ready    = w_ready;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule
